// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//
// Shares one signed sequential 8x8 multiplier between two requesters.
// A round-robin choice picks an owner in IDLE and latches that owner's
// operands; the block then pulses mult_start, waits for mult_IsDone and
// returns the product with a one-cycle done pulse to the owner. A watchdog
// aborts an operation after TIMEOUT BUSY cycles without mult_IsDone.
//
// Handshake: reqN is a level held high with aN/bN stable until doneN
// pulses. doneN is a single-cycle pulse. A req still high in the IDLE cycle
// after DONE is a new request.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   req0/req1, a0/b0/a1/b1  request levels and signed 8-bit operands
//   done0/done1             one-cycle completion pulse to the owner
//   result, result_neg      product / sign of the last completed operation
//   err                     one-cycle pulse with done on a timeout abort
//   busy                    high in every state except IDLE
//   owner                   index of the current or last owner
//   mult_start              start pulse to the multiplier
//   mult_InA, mult_InB      registered operands to the multiplier
//   mult_IsDone/IsNeg/product  multiplier status and result
//   state_dbg               current FSM state (debug visibility)

module mult_share_arbiter #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [7:0]  a0,
  input  logic [7:0]  b0,
  input  logic [7:0]  a1,
  input  logic [7:0]  b1,
  output logic        done0,
  output logic        done1,
  output logic [15:0] result,
  output logic        result_neg,
  output logic        err,
  output logic        busy,
  output logic        owner,
  output logic        mult_start,
  output logic [7:0]  mult_InA,
  output logic [7:0]  mult_InB,
  input  logic        mult_IsDone,
  input  logic        mult_IsNeg,
  input  logic [15:0] mult_product,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_ARM   = 3'd2,
    S_BUSY  = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // Last BUSY count value before the watchdog fires.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        tmo_q, tmo_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] result_q, result_d;
  logic        neg_q, neg_d;
  logic [7:0]  ina_q, ina_d;
  logic [7:0]  inb_q, inb_d;
  logic        busy_q, busy_d;
  logic        grant;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    tmo_d    = tmo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    neg_d    = neg_q;
    ina_d    = ina_q;
    inb_d    = inb_q;
    grant    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester that did not own last time wins;
          // otherwise the single active requester wins.
          grant   = (req0 && req1) ? ~last_q : req1;
          owner_d = grant;
          ina_d   = grant ? a1 : a0;
          inb_d   = grant ? b1 : b0;
          state_d = S_START;
        end
      end
      S_START: state_d = S_ARM;
      S_ARM: begin
        // IsDone may still be high from the previous operation; ignore it.
        cnt_d   = 8'd0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        cnt_d = cnt_q + 8'd1;
        if (mult_IsDone) begin
          // Completion wins over a timeout landing on the same cycle.
          result_d = mult_product;
          neg_d    = mult_IsNeg;
          state_d  = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          result_d = 16'd0;
          neg_d    = 1'b0;
          tmo_d    = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        tmo_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      tmo_q    <= 1'b0;
      cnt_q    <= 8'd0;
      result_q <= 16'd0;
      neg_q    <= 1'b0;
      ina_q    <= 8'd0;
      inb_q    <= 8'd0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      tmo_q    <= tmo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      ina_q    <= ina_d;
      inb_q    <= inb_d;
      busy_q   <= busy_d;
    end
  end

  // Pulses decoded from the registered state plus registered owner/flag.
  assign mult_start = (state_q == S_START);
  assign done0      = (state_q == S_DONE) && !owner_q;
  assign done1      = (state_q == S_DONE) && owner_q;
  assign err        = (state_q == S_DONE) && tmo_q;

  assign result     = result_q;
  assign result_neg = neg_q;
  assign busy       = busy_q;
  assign owner      = owner_q;
  assign mult_InA   = ina_q;
  assign mult_InB   = inb_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter with a behavioural multiplier
// stub (normal / hung / stale-IsDone) and a reference model of the
// arbitration, latency and result rules.

module tb_mult_share_arbiter;

  localparam int TIMEOUT  = 8;
  localparam int MAX_WAIT = 40;
  localparam int M_NORMAL = 0;
  localparam int M_HANG   = 1;
  localparam int M_STALE  = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        req0 = 0, req1 = 0;
  logic [7:0]  a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic        done0, done1, result_neg, err, busy, owner, mult_start;
  logic [15:0] result;
  logic [7:0]  mult_InA, mult_InB;
  logic        mult_IsDone = 1'b0, mult_IsNeg = 1'b0;
  logic [15:0] mult_product = 16'd0;
  logic [2:0]  state_dbg;

  mult_share_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .done0(done0), .done1(done1),
    .result(result), .result_neg(result_neg),
    .err(err), .busy(busy), .owner(owner),
    .mult_start(mult_start), .mult_InA(mult_InA), .mult_InB(mult_InB),
    .mult_IsDone(mult_IsDone), .mult_IsNeg(mult_IsNeg),
    .mult_product(mult_product), .state_dbg(state_dbg)
  );

  // ---------------- multiplier stub ----------------
  int          stub_mode = M_NORMAL;
  int          stub_lat  = 2;
  int          stub_cnt  = 0;
  logic [15:0] stub_res  = 16'd0;
  logic        stub_neg  = 1'b0;

  always @(negedge clk) begin
    int p;
    if (stub_mode == M_HANG) begin
      mult_IsDone = 1'b0;
      stub_cnt    = 0;
    end else if (mult_start) begin
      p        = int'($signed(mult_InA)) * int'($signed(mult_InB));
      stub_res = p[15:0];
      stub_neg = (p < 0);
      if (stub_mode == M_NORMAL) begin
        mult_IsDone = 1'b0;
        stub_cnt    = stub_lat;
      end else begin
        stub_cnt = 4;  // stale IsDone stays high through ARM
      end
    end else if (stub_cnt > 0) begin
      stub_cnt = stub_cnt - 1;
      if (stub_mode == M_STALE && (stub_cnt == 2 || stub_cnt == 1)) begin
        mult_IsDone = 1'b0;
      end else if (stub_cnt == 0) begin
        mult_IsDone  = 1'b1;
        mult_product = stub_res;
        mult_IsNeg   = stub_neg;
      end
    end else if (stub_mode == M_STALE) begin
      mult_IsDone  = 1'b1;
      mult_product = 16'h7777;
      mult_IsNeg   = 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [18:0] exp_q[$];  // {owner, err, neg, product}
  bit          m_last = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return {(p < 0), p[15:0]};
  endfunction

  // First cycle (relative to the IDLE sample at cycle 0) in which the
  // multiplier's IsDone is seen while the block is waiting for it.
  function automatic int first_seen(input int mode, input int lat);
    if (mode == M_STALE) return 5;
    if (mode == M_HANG) return 1000;
    return (1 + lat < 3) ? 3 : 1 + lat;
  endfunction

  function automatic bit is_timeout(input int mode, input int lat);
    return first_seen(mode, lat) > 2 + TIMEOUT;
  endfunction

  function automatic int exp_lat(input int mode, input int lat);
    if (is_timeout(mode, lat)) return 3 + TIMEOUT;
    return first_seen(mode, lat) + 1;
  endfunction

  // Apply the arbitration rule to the current request pattern and queue
  // the expected outcome.
  task automatic issue(output int exp_cyc, output bit w);
    logic [7:0]  a, b;
    logic [16:0] m;
    bit          to;
    w       = (req0 && req1) ? !m_last : req1;
    a       = w ? a1 : a0;
    b       = w ? b1 : b0;
    m       = model_mul(a, b);
    to      = is_timeout(stub_mode, stub_lat);
    exp_cyc = exp_lat(stub_mode, stub_lat);
    if (to) m = 17'd0;
    exp_q.push_back({w, to, m});
    m_last = w;
  endtask

  // ---------------- driver / monitor tasks ----------------
  task automatic wait_done(input bit mutate, output int cyc, output int n_start,
                           output int start_cyc, output logic moved,
                           output logic d0, output logic d1, output logic e,
                           output logic gap);
    logic [7:0] ia, ib;
    cyc = -1; n_start = 0; start_cyc = -1; moved = 0; gap = 0;
    d0 = 0; d1 = 0; e = 0; ia = 0; ib = 0;
    for (int n = 1; n <= MAX_WAIT; n++) begin
      @(negedge clk);
      if (mult_start) begin
        n_start++;
        if (start_cyc < 0) start_cyc = n;
      end
      if (n == 1) begin
        ia = mult_InA;
        ib = mult_InB;
      end else if (mult_InA !== ia || mult_InB !== ib) begin
        moved = 1;
      end
      if (busy !== 1'b1) gap = 1;
      if (mutate && n == 1) a0 = 8'd100;
      if (mutate && n == 2) req0 = 1'b0;
      if (done0 || done1) begin
        cyc = n; d0 = done0; d1 = done1; e = err;
        return;
      end
    end
  endtask

  task automatic run_op(input string tag, input int exp_cyc, input bit mutate,
                        output logic obs_owner);
    int          cyc, n_start, start_cyc;
    logic        moved, d0, d1, e, gap;
    logic [18:0] exp;
    wait_done(mutate, cyc, n_start, start_cyc, moved, d0, d1, e, gap);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 19'h7FFFF;
    obs_owner = d1;
    check({tag, "_latency"}, cyc, exp_cyc);
    check({tag, "_done0"}, d0, !exp[18]);
    check({tag, "_done1"}, d1, exp[18]);
    check({tag, "_err"}, e, exp[17]);
    check({tag, "_result"}, result, exp[15:0]);
    check({tag, "_result_neg"}, result_neg, exp[16]);
    check({tag, "_owner"}, owner, exp[18]);
    check({tag, "_start_count"}, n_start, 1);
    check({tag, "_start_cycle"}, start_cyc, 1);
    check({tag, "_operands_stable"}, moved, 0);
    check({tag, "_busy_high"}, gap, 0);
    @(negedge clk);  // fixed IDLE cycle
    check({tag, "_idle_pulses"}, {done0, done1, err, mult_start}, 4'b0);
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_result_held"}, result, exp[15:0]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_done"}, {done0, done1, err, mult_start}, 4'b0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_owner"}, owner, 0);
    check({tag, "_result"}, result, 16'd0);
    check({tag, "_result_neg"}, result_neg, 0);
    check({tag, "_mult_in"}, {mult_InA, mult_InB}, 16'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed=stuck expected=finish");
    $fatal(1, "bench time limit");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    int   ec;
    bit   w, p0, p1;
    logic ow;
    int   order[4];

    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single request: 5 * -3
    stub_mode = M_NORMAL; stub_lat = 3;
    a0 = 8'd5; b0 = 8'hFD; req0 = 1;
    issue(ec, w);
    run_op("single", ec, 0, ow);

    // Operand stability: a0 changes after grant, req drops mid-operation
    a0 = 8'd9; b0 = 8'd7; req0 = 1; stub_lat = 4;
    issue(ec, w);
    run_op("stable", ec, 1, ow);
    check("stable_inA_held", mult_InA, 8'd9);
    req0 = 0;

    // Timeout with a hung multiplier
    stub_mode = M_HANG; a1 = 8'd3; b1 = 8'd3; req1 = 1;
    issue(ec, w);
    run_op("timeout", ec, 0, ow);
    req1 = 0;

    // Next request after the timeout proceeds normally: -128 * -128
    stub_mode = M_NORMAL; stub_lat = 2;
    a1 = 8'h80; b1 = 8'h80; req1 = 1;
    issue(ec, w);
    run_op("after_timeout", ec, 0, ow);
    req1 = 0;

    // IsDone on the last watchdog cycle wins: 127 * -128
    stub_lat = 9; a0 = 8'd127; b0 = 8'h80; req0 = 1;
    issue(ec, w);
    run_op("tie_isdone", ec, 0, ow);
    req0 = 0;

    // IsDone one cycle too late: timeout
    stub_lat = 10; a1 = 8'd6; b1 = 8'd6; req1 = 1;
    issue(ec, w);
    run_op("late_isdone", ec, 0, ow);
    req1 = 0;

    // Stale IsDone held high through ARM: 12 * -11
    stub_mode = M_STALE;
    @(negedge clk);
    a0 = 8'd12; b0 = 8'hF5; req0 = 1;
    issue(ec, w);
    run_op("stale", ec, 0, ow);
    req0 = 0;
    stub_mode = M_NORMAL;
    @(negedge clk);

    // Reset in the middle of BUSY
    stub_lat = 6; a0 = 8'd3; b0 = 8'd3; req0 = 1;
    repeat (4) @(negedge clk);
    reset = 1'b1; req0 = 0;
    @(negedge clk);
    check_reset_values("midreset");
    @(negedge clk);
    check("midreset_no_done", {done0, done1}, 2'b0);
    reset = 1'b0;
    m_last = 1'b1;
    exp_q.delete();

    // Round robin with both requests held: 2*3 and -4*7
    a0 = 8'd2; b0 = 8'd3; a1 = 8'hFC; b1 = 8'd7; req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      stub_lat = $urandom_range(1, 5);
      issue(ec, w);
      run_op("rr", ec, 0, ow);
      order[i] = int'(ow);
    end
    check("rr_order", {order[0][0], order[1][0], order[2][0], order[3][0]}, 4'b0101);
    req0 = 0; req1 = 0;

    // Random traffic
    p0 = 0; p1 = 0;
    for (int i = 0; i < 30; i++) begin
      stub_lat = $urandom_range(1, 7);
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; a0 = 8'($urandom); b0 = 8'($urandom);
      end
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1; a1 = 8'($urandom); b1 = 8'($urandom);
      end
      if (!p0 && !p1) begin
        p0 = 1; a0 = 8'($urandom); b0 = 8'($urandom);
      end
      req0 = p0; req1 = p1;
      issue(ec, w);
      run_op("rand", ec, 0, ow);
      if (w) p1 = 0; else p0 = 0;
    end
    req0 = 0; req1 = 0;
    @(negedge clk);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
